// File: rtl/ccd_cap_pkg.sv
// ccd_cap_pkg
//   Shared types and constants for the windowed CCD capture slice.
//   - cap_state_e  : capture FSM state encoding
//   - DEF_*        : default datapath widths
//   - DECIM_*/WIN_MIN : legal parameter ranges, clamped by the top level
package ccd_cap_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } cap_state_e;

  localparam int unsigned DEF_DATA_W  = 12;
  localparam int unsigned DEF_CNT_W   = 16;
  localparam int unsigned DEF_FRAME_W = 32;

  localparam int unsigned DECIM_MIN = 1;
  localparam int unsigned DECIM_MAX = 16;
  localparam int unsigned WIN_MIN   = 1;

  // Decimation phase runs 0..DECIM-1, so it must hold DECIM_MAX-1.
  localparam int unsigned PHASE_W = $clog2(DECIM_MAX);

  function automatic int unsigned clamp_decim(input int unsigned d);
    if (d < DECIM_MIN) return DECIM_MIN;
    if (d > DECIM_MAX) return DECIM_MAX;
    return d;
  endfunction

endpackage : ccd_cap_pkg

// File: rtl/ccd_axis_counter.sv
// ccd_axis_counter
//   One axis (column or row) of the capture window. Tracks the raw position
//   along the axis, whether it lies in [START, START+LEN), the decimation
//   phase relative to START and the decimated window index.
//   Ports:
//     i_clk, i_rst_n : clock, asynchronous active-low reset
//     i_clear        : restart the axis at raw position 0 (wins over i_step)
//     i_step         : advance one raw position (saturates at all-ones)
//     o_in_window    : current raw position is inside the window
//     o_keep         : inside the window and on a decimation phase of 0
//     o_index        : (raw - START) / DECIM for the current position
module ccd_axis_counter
  import ccd_cap_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned START = 0,
  parameter int unsigned LEN   = 1,
  parameter int unsigned DECIM = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_step,
  output logic             o_in_window,
  output logic             o_keep,
  output logic [CNT_W-1:0] o_index
);

  // One extra bit so a window running past the counter range still compares.
  localparam logic [CNT_W:0]     WIN_LO     = (CNT_W+1)'(START);
  localparam logic [CNT_W:0]     WIN_HI     = (CNT_W+1)'(START + LEN);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(DECIM - 1);

  logic [CNT_W-1:0]   raw_q, raw_d;
  logic [CNT_W-1:0]   index_q, index_d;
  logic [PHASE_W-1:0] phase_q, phase_d;

  assign o_in_window = ({1'b0, raw_q} >= WIN_LO) && ({1'b0, raw_q} < WIN_HI);
  assign o_keep      = o_in_window && (phase_q == '0);
  assign o_index     = index_q;

  always_comb begin
    raw_d   = raw_q;
    phase_d = phase_q;
    index_d = index_q;
    if (i_clear) begin
      raw_d   = '0;
      phase_d = '0;
      index_d = '0;
    end else if (i_step && !(&raw_q)) begin
      raw_d = raw_q + 1'b1;
      // Phase/index only move while inside the window, so they read 0/0
      // exactly when the raw position reaches START: no divider needed.
      if (o_in_window) begin
        if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          index_d = index_q + 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      raw_q   <= '0;
      phase_q <= '0;
      index_q <= '0;
    end else begin
      raw_q   <= raw_d;
      phase_q <= phase_d;
      index_q <= index_d;
    end
  end

endmodule : ccd_axis_counter

// File: rtl/ccd_window_capture.sv
// ccd_window_capture
//   Frame-aligned raw Bayer capture with crop window and integer decimation.
//   Sits between the registered sensor pins and the RAW2RGB converter.
//   Ports:
//     i_clk, i_rst_n        : pixel clock, asynchronous active-low reset
//     i_start / i_end       : single-cycle arm / stop pulses (i_end wins)
//     i_data, i_fval, i_lval: registered sensor pixel, frame and line valid
//     o_data, o_dval        : kept pixel, 1-cycle latency; o_data holds when idle
//     o_x, o_y              : decimated window-relative column / row
//     o_frame_cnt           : completed captured frames (wrapping)
//     o_frame_done          : one-cycle pulse at the end of a captured frame
//     o_busy                : FSM is not IDLE
//     o_line_len            : last complete line length of the last captured frame
//     o_frame_lines         : line count of the last captured frame
//   Build option: define CCD_CAPTURE_STATS_EN to build the o_line_len /
//   o_frame_lines statistics; otherwise both ports read 0.
module ccd_window_capture
  import ccd_cap_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned FRAME_W = DEF_FRAME_W,
  parameter int unsigned X_START = 0,
  parameter int unsigned Y_START = 0,
  parameter int unsigned WIN_W   = 1280,
  parameter int unsigned WIN_H   = 960,
  parameter int unsigned DECIM   = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic               i_end,
  input  logic [DATA_W-1:0]  i_data,
  input  logic               i_fval,
  input  logic               i_lval,
  output logic [DATA_W-1:0]  o_data,
  output logic               o_dval,
  output logic [CNT_W-1:0]   o_x,
  output logic [CNT_W-1:0]   o_y,
  output logic [FRAME_W-1:0] o_frame_cnt,
  output logic               o_frame_done,
  output logic               o_busy,
  output logic [CNT_W-1:0]   o_line_len,
  output logic [CNT_W-1:0]   o_frame_lines
);

  localparam int unsigned DECIM_EFF = clamp_decim(DECIM);
  localparam int unsigned WIN_W_EFF = (WIN_W < WIN_MIN) ? WIN_MIN : WIN_W;
  localparam int unsigned WIN_H_EFF = (WIN_H < WIN_MIN) ? WIN_MIN : WIN_H;

  cap_state_e state_q, state_d;
  logic       stop_pend_q, stop_pend_d;

  logic fval_q, fval_d;
  logic line_q, line_d;
  logic line_act;
  logic fval_rise, fval_fall, line_fall;
  logic cap_en, frame_end;

  logic             x_clear, x_step, x_in, x_keep;
  logic             y_clear, y_step, y_in, y_keep;
  logic [CNT_W-1:0] x_idx, y_idx;
  logic             keep;

  logic [DATA_W-1:0]  data_q, data_d;
  logic               dval_q, dval_d;
  logic [CNT_W-1:0]   x_q, x_d, y_q, y_d;
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
  logic               frame_done_q, frame_done_d;

  // LVAL is only meaningful inside FVAL, so line edges use the gated copy.
  assign line_act  = i_fval & i_lval;
  assign fval_d    = i_fval;
  assign line_d    = line_act;
  assign fval_rise = i_fval & ~fval_q;
  assign fval_fall = ~i_fval & fval_q;
  assign line_fall = ~line_act & line_q;

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    unique case (state_q)
      IDLE: begin
        if (i_start && !i_end) state_d = ARMED;
      end
      ARMED: begin
        if (i_end)          state_d = IDLE;
        else if (fval_rise) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (i_end) stop_pend_d = 1'b1;
        if (fval_fall) begin
          state_d     = (stop_pend_q || i_end) ? IDLE : ARMED;
          stop_pend_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        stop_pend_d = 1'b0;
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    cap_en    = (state_q == CAPTURE);
    frame_end = cap_en & fval_fall;
  end

  assign o_busy = (state_q != IDLE);

  // Counters restart on fval rise while still ARMED so the first pixel of
  // the frame lands on raw (0,0); stepping only happens during CAPTURE.
  assign x_clear = line_fall | fval_rise;
  assign x_step  = cap_en & line_act;
  assign y_clear = fval_rise;
  assign y_step  = cap_en & line_fall;

  ccd_axis_counter #(
    .CNT_W (CNT_W),
    .START (X_START),
    .LEN   (WIN_W_EFF),
    .DECIM (DECIM_EFF)
  ) u_x_cnt (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (x_clear),
    .i_step      (x_step),
    .o_in_window (x_in),
    .o_keep      (x_keep),
    .o_index     (x_idx)
  );

  ccd_axis_counter #(
    .CNT_W (CNT_W),
    .START (Y_START),
    .LEN   (WIN_H_EFF),
    .DECIM (DECIM_EFF)
  ) u_y_cnt (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_clear     (y_clear),
    .i_step      (y_step),
    .o_in_window (y_in),
    .o_keep      (y_keep),
    .o_index     (y_idx)
  );

  assign keep = cap_en & line_act & x_in & y_in & x_keep & y_keep;

  always_comb begin
    data_d       = data_q;
    x_d          = x_q;
    y_d          = y_q;
    dval_d       = keep;
    frame_done_d = frame_end;
    frame_cnt_d  = frame_cnt_q;
    if (keep) begin
      data_d = i_data;
      x_d    = x_idx;
      y_d    = y_idx;
    end
    if (frame_end) frame_cnt_d = frame_cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fval_q       <= 1'b0;
      line_q       <= 1'b0;
      data_q       <= '0;
      dval_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      fval_q       <= fval_d;
      line_q       <= line_d;
      data_q       <= data_d;
      dval_q       <= dval_d;
      x_q          <= x_d;
      y_q          <= y_d;
      frame_cnt_q  <= frame_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_data       = data_q;
  assign o_dval       = dval_q;
  assign o_x          = x_q;
  assign o_y          = y_q;
  assign o_frame_cnt  = frame_cnt_q;
  assign o_frame_done = frame_done_q;

`ifdef CCD_CAPTURE_STATS_EN
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [CNT_W-1:0] last_len_q, last_len_d;
  logic [CNT_W-1:0] line_len_q, line_len_d;
  logic [CNT_W-1:0] frame_lines_q, frame_lines_d;

  // Unwindowed raw counts, kept separately from the axis counters.
  always_comb begin
    pix_cnt_d     = pix_cnt_q;
    line_cnt_d    = line_cnt_q;
    last_len_d    = last_len_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;
    if (x_clear)                   pix_cnt_d = '0;
    else if (x_step && !(&pix_cnt_q)) pix_cnt_d = pix_cnt_q + 1'b1;
    if (y_clear)                    line_cnt_d = '0;
    else if (y_step && !(&line_cnt_q)) line_cnt_d = line_cnt_q + 1'b1;
    if (y_step) last_len_d = pix_cnt_q;
    // Next-state values so a line ending on the same edge as FVAL counts.
    if (frame_end) begin
      line_len_d    = last_len_d;
      frame_lines_d = line_cnt_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pix_cnt_q     <= '0;
      line_cnt_q    <= '0;
      last_len_q    <= '0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
    end else begin
      pix_cnt_q     <= pix_cnt_d;
      line_cnt_q    <= line_cnt_d;
      last_len_q    <= last_len_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
    end
  end

  assign o_line_len    = line_len_q;
  assign o_frame_lines = frame_lines_q;
`else
  assign o_line_len    = '0;
  assign o_frame_lines = '0;
`endif

endmodule : ccd_window_capture

// File: tb/tb_ccd_window_capture.sv
module tb_ccd_window_capture;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic        i_end;
  logic [11:0] i_data;
  logic        i_fval;
  logic        i_lval;

  logic [11:0] f_data, w_data;
  logic        f_dval, w_dval;
  logic [15:0] f_x, f_y, w_x, w_y;
  logic [31:0] f_cnt, w_cnt;
  logic        f_done, w_done;
  logic        f_busy, w_busy;
  logic [15:0] f_len, f_lines, w_len, w_lines;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [11:0] d;
  } px_t;

  px_t exp_f[$];
  px_t exp_w[$];
  px_t fe, we;

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned f_done_n;
  int unsigned w_done_n;
  logic [11:0] last_in;

`ifdef CCD_CAPTURE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  ccd_window_capture #(
    .DATA_W  (12),
    .CNT_W   (16),
    .FRAME_W (32),
    .X_START (0),
    .Y_START (0),
    .WIN_W   (10),
    .WIN_H   (4),
    .DECIM   (1)
  ) dut_full (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (i_start),
    .i_end         (i_end),
    .i_data        (i_data),
    .i_fval        (i_fval),
    .i_lval        (i_lval),
    .o_data        (f_data),
    .o_dval        (f_dval),
    .o_x           (f_x),
    .o_y           (f_y),
    .o_frame_cnt   (f_cnt),
    .o_frame_done  (f_done),
    .o_busy        (f_busy),
    .o_line_len    (f_len),
    .o_frame_lines (f_lines)
  );

  ccd_window_capture #(
    .DATA_W  (12),
    .CNT_W   (16),
    .FRAME_W (32),
    .X_START (2),
    .Y_START (1),
    .WIN_W   (4),
    .WIN_H   (3),
    .DECIM   (2)
  ) dut_win (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (i_start),
    .i_end         (i_end),
    .i_data        (i_data),
    .i_fval        (i_fval),
    .i_lval        (i_lval),
    .o_data        (w_data),
    .o_dval        (w_dval),
    .o_x           (w_x),
    .o_y           (w_y),
    .o_frame_cnt   (w_cnt),
    .o_frame_done  (w_done),
    .o_busy        (w_busy),
    .o_line_len    (w_len),
    .o_frame_lines (w_lines)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pixel value encodes its raw position so data checks also check ordering.
  task automatic drive_frame(input int lines, input int pix, input int start_at, input int end_at);
    i_fval = 1'b1;
    tick();
    tick();
    for (int l = 0; l < lines; l++) begin
      if (l == start_at) i_start = 1'b1;
      if (l == end_at)   i_end   = 1'b1;
      tick();
      i_start = 1'b0;
      i_end   = 1'b0;
      for (int p = 0; p < pix; p++) begin
        i_lval = 1'b1;
        i_data = 12'(l * 64 + p);
        tick();
      end
      i_lval = 1'b0;
      tick();
      tick();
      tick();
    end
    tick();
    i_fval = 1'b0;
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic push_full(input int lines, input int pix);
    for (int l = 0; l < lines; l++)
      for (int p = 0; p < pix; p++)
        exp_f.push_back('{x: 16'(p), y: 16'(l), d: 12'(l * 64 + p)});
  endtask

  task automatic push_win(input logic [15:0] x, input logic [15:0] y, input logic [11:0] d);
    exp_w.push_back('{x: x, y: y, d: d});
  endtask

  always @(posedge clk) last_in <= i_data;

  always @(negedge clk) begin
    if (rst_n) begin
      if (f_dval) begin
        if (exp_f.size() == 0) begin
          check_eq("full_extra_dval", 32'(f_dval), 32'd0);
        end else begin
          fe = exp_f.pop_front();
          check_eq("full_x", 32'(f_x), 32'(fe.x));
          check_eq("full_y", 32'(f_y), 32'(fe.y));
          check_eq("full_data", 32'(f_data), 32'(fe.d));
          check_eq("full_latency", 32'(f_data), 32'(last_in));
        end
      end
      if (w_dval) begin
        if (exp_w.size() == 0) begin
          check_eq("win_extra_dval", 32'(w_dval), 32'd0);
        end else begin
          we = exp_w.pop_front();
          check_eq("win_x", 32'(w_x), 32'(we.x));
          check_eq("win_y", 32'(w_y), 32'(we.y));
          check_eq("win_data", 32'(w_data), 32'(we.d));
          check_eq("win_latency", 32'(w_data), 32'(last_in));
        end
      end
      if (f_done) f_done_n++;
      if (w_done) w_done_n++;
    end
  end

  task automatic check_after(input string tag, input int unsigned cnt, input logic busy,
                             input int unsigned len, input int unsigned lines);
    check_eq({tag, "_full_left"}, 32'(exp_f.size()), 32'd0);
    check_eq({tag, "_win_left"}, 32'(exp_w.size()), 32'd0);
    check_eq({tag, "_full_cnt"}, f_cnt, 32'(cnt));
    check_eq({tag, "_win_cnt"}, w_cnt, 32'(cnt));
    check_eq({tag, "_full_done_n"}, f_done_n, 32'(cnt));
    check_eq({tag, "_win_done_n"}, w_done_n, 32'(cnt));
    check_eq({tag, "_full_busy"}, 32'(f_busy), 32'(busy));
    check_eq({tag, "_win_busy"}, 32'(w_busy), 32'(busy));
    check_eq({tag, "_full_len"}, 32'(f_len), STATS ? 32'(len) : 32'd0);
    check_eq({tag, "_full_lines"}, 32'(f_lines), STATS ? 32'(lines) : 32'd0);
    check_eq({tag, "_win_len"}, 32'(w_len), STATS ? 32'(len) : 32'd0);
    check_eq({tag, "_win_lines"}, 32'(w_lines), STATS ? 32'(lines) : 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    f_done_n = 0;
    w_done_n = 0;
    rst_n    = 1'b0;
    i_start  = 1'b0;
    i_end    = 1'b0;
    i_data   = 12'h5a5;
    i_fval   = 1'b1;
    i_lval   = 1'b1;

    // Reset asserted while a line is in flight.
    tick();
    tick();
    tick();
    check_eq("rst_dval", 32'(f_dval), 32'd0);
    check_eq("rst_data", 32'(f_data), 32'd0);
    check_eq("rst_x", 32'(f_x), 32'd0);
    check_eq("rst_y", 32'(f_y), 32'd0);
    check_eq("rst_cnt", f_cnt, 32'd0);
    check_eq("rst_done", 32'(f_done), 32'd0);
    check_eq("rst_busy", 32'(f_busy), 32'd0);
    check_eq("rst_win_busy", 32'(w_busy), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    i_lval = 1'b0;
    tick();
    i_fval = 1'b0;
    tick();
    tick();

    // Frame without i_start: nothing captured.
    drive_frame(4, 10, -1, -1);
    check_after("nostart", 0, 1'b0, 0, 0);

    // Arm and capture one full 4x10 frame.
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick();
    check_eq("armed_busy", 32'(f_busy), 32'd1);
    push_full(4, 10);
    push_win(16'd0, 16'd0, 12'd66);
    push_win(16'd1, 16'd0, 12'd68);
    push_win(16'd0, 16'd1, 12'd194);
    push_win(16'd1, 16'd1, 12'd196);
    drive_frame(4, 10, -1, -1);
    check_after("frame1", 1, 1'b1, 10, 4);

    // Smaller physical frame than the window: only existing pixels kept.
    push_full(3, 7);
    push_win(16'd0, 16'd0, 12'd66);
    push_win(16'd1, 16'd0, 12'd68);
    drive_frame(3, 7, -1, -1);
    check_after("frame2", 2, 1'b1, 7, 3);

    // i_end mid-capture: frame completes, then back to IDLE.
    push_full(4, 10);
    push_win(16'd0, 16'd0, 12'd66);
    push_win(16'd1, 16'd0, 12'd68);
    push_win(16'd0, 16'd1, 12'd194);
    push_win(16'd1, 16'd1, 12'd196);
    drive_frame(4, 10, -1, 1);
    check_after("stop", 3, 1'b0, 10, 4);

    // Idle again: further frames ignored, stats hold.
    drive_frame(4, 10, -1, -1);
    check_after("after_stop", 3, 1'b0, 10, 4);

    // i_start together with i_end in IDLE: stays IDLE.
    i_start = 1'b1;
    i_end   = 1'b1;
    tick();
    i_start = 1'b0;
    i_end   = 1'b0;
    tick();
    check_eq("start_end_full_busy", 32'(f_busy), 32'd0);
    check_eq("start_end_win_busy", 32'(w_busy), 32'd0);

    // Start while FVAL is already high: that frame is skipped.
    drive_frame(4, 10, 1, -1);
    check_after("midstart", 3, 1'b1, 10, 4);

    // The following frame is captured completely; count continues.
    push_full(4, 10);
    push_win(16'd0, 16'd0, 12'd66);
    push_win(16'd1, 16'd0, 12'd68);
    push_win(16'd0, 16'd1, 12'd194);
    push_win(16'd1, 16'd1, 12'd196);
    drive_frame(4, 10, -1, -1);
    check_after("restart", 4, 1'b1, 10, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_ccd_window_capture
